// File: rtl/pixel_pkg.sv
// pixel_pkg: shared colour type, frame FSM states and latch colour for the LED frame sequencer
package pixel_pkg;
  typedef logic [23:0] color_t;
  typedef enum logic [1:0] {IDLE, LOAD, SEND, LATCH} state_t;
  localparam color_t LATCH_COLOR = 24'h0;
  function automatic color_t dim_color(color_t c, logic [2:0] s);
    return {c[23:16] >> s, c[15:8] >> s, c[7:0] >> s};
  endfunction
endpackage

// File: rtl/pixel_frame_ram.sv
// pixel_frame_ram: NUM_PX x 24 colour buffer, one write port, one registered read-first read port, no reset
module pixel_frame_ram
  import pixel_pkg::*;
#(
  parameter int NUM_PX = 3,
  localparam int AW = NUM_PX > 1 ? $clog2(NUM_PX) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  color_t        wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output color_t        rd_data
);
  color_t mem [NUM_PX];
  // read data only updates when a read is issued so it holds while the pixel waits for acceptance
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/pixel_frame_ctrl.sv
// pixel_frame_ctrl: streams the colour buffer to pixel_driver on each frame tick, then latches; PIXEL_FRAME_DIM_EN adds brightness shift
module pixel_frame_ctrl
  import pixel_pkg::*;
#(
  parameter int NUM_PX = 3,
  parameter int FRAME_DIV = 266_667,
  localparam int AW = NUM_PX > 1 ? $clog2(NUM_PX) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  color_t        wr_data,
  input  logic [2:0]    dim,
  output color_t        px_color,
  output logic          px_valid,
  output logic          px_reset,
  input  logic          px_ready,
  output logic          busy,
  output logic          frame_done,
  output logic          overrun
);
  localparam logic [AW-1:0] LAST = AW'(NUM_PX - 1);
  state_t state, state_nx;
  logic [AW-1:0] idx, idx_nx;
  logic [31:0] cnt;
  logic tick;
  color_t rd_data, send_color;
  assign tick = cnt == 32'(FRAME_DIV - 1);
  pixel_frame_ram #(.NUM_PX(NUM_PX)) u_ram (
    .clk(clk),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_en(state == LOAD),
    .rd_addr(idx),
    .rd_data(rd_data)
  );
`ifdef PIXEL_FRAME_DIM_EN
  assign send_color = dim_color(rd_data, dim);
`else
  logic unused_dim;
  assign unused_dim = ^dim;
  assign send_color = rd_data;
`endif
  assign px_valid = state == SEND || state == LATCH;
  assign px_reset = state == LATCH;
  assign px_color = state == SEND ? send_color : LATCH_COLOR;
  assign busy     = state != IDLE;
  // next state: one read bubble per pixel, latch after the last pixel, back to idle once latch is taken
  always_comb begin
    state_nx = state;
    idx_nx = idx;
    case (state)
      IDLE: if (tick && enable) begin
        state_nx = LOAD;
        idx_nx = '0;
      end
      LOAD: state_nx = SEND;
      SEND: if (px_ready) begin
        state_nx = idx == LAST ? LATCH : LOAD;
        idx_nx = idx == LAST ? idx : idx + 1'b1;
      end
      default: if (px_ready) state_nx = IDLE;
    endcase
  end
  // state, frame tick counter, done pulse and sticky overrun flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      frame_done <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      idx <= idx_nx;
      cnt <= tick ? '0 : cnt + 32'd1;
      frame_done <= state == LATCH && px_ready;
      overrun <= overrun | (tick && busy);
    end
  end
endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// tb_pixel_frame_ctrl: directed self-checking bench for pixel_frame_ctrl
module tb_pixel_frame_ctrl;
  import pixel_pkg::*;
  logic clk = 1'b0;
  logic rst, enable, wr_en, px_ready, ready_f;
  logic [1:0] wr_addr;
  color_t wr_data;
  logic [2:0] dim;
  color_t px_color, f_color;
  logic px_valid, px_reset, busy, frame_done, overrun;
  logic f_valid, f_reset, f_busy, f_done, f_overrun;
  int checks = 0, errors = 0;
  int n, fd, lat, hits;
  logic done, hold, pr;
  color_t pc;
  logic [24:0] acc [8];
  logic [27:0] exp_f1 [9] = '{28'h8000000, 28'h9FF0000, 28'h8000000, 28'h900FF00, 28'h8000000,
                              28'h90000FF, 28'hB000000, 28'h4000000, 28'h0000000};
  always #5 clk = ~clk;
  pixel_frame_ctrl #(.NUM_PX(3), .FRAME_DIV(50)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dim(dim), .px_color(px_color), .px_valid(px_valid), .px_reset(px_reset), .px_ready(px_ready),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );
  pixel_frame_ctrl #(.NUM_PX(3), .FRAME_DIV(4)) dut_fast (
    .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dim(dim), .px_color(f_color), .px_valid(f_valid), .px_reset(f_reset), .px_ready(ready_f),
    .busy(f_busy), .frame_done(f_done), .overrun(f_overrun)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input color_t d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask
  initial begin
    rst = 1'b1; enable = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; dim = 3'd0;
    px_ready = 1'b1; ready_f = 1'b0;
    step();
    step();
    wr(2'd0, 24'hFF0000);
    wr(2'd1, 24'h00FF00);
    wr(2'd2, 24'h0000FF);
    check("rst_out", {4'(busy), 4'(frame_done), 4'(px_reset), 4'(px_valid), px_color}, 32'h0);
    check("rst_ovr", 32'(overrun), 32'h0);
    rst = 1'b0;
    n = 0;
    while (!busy && n < 100) begin
      step();
      n++;
    end
    check("tick_lat", n, 50);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) step();
      check($sformatf("frame1_%0d", i), {busy, frame_done, px_reset, px_valid, px_color}, 32'(exp_f1[i]));
    end
    check("fast_ovr", 32'(f_overrun), 32'h1);
    check("fast_busy", 32'(f_busy), 32'h1);
    check("fast_valid", 32'(f_valid), 32'h1);
    check("fast_color", f_color, 32'hFF0000);
    done = 1'b0; hold = 1'b0; n = 0; pc = '0; pr = 1'b0;
    for (int i = 0; i < 8; i++) acc[i] = '0;
    for (int i = 0; i < 300 && !done; i++) begin
      step();
      if (hold) begin
        check("bp_valid", 32'(px_valid), 32'h1);
        check("bp_color", px_color, pc);
        check("bp_reset", 32'(px_reset), 32'(pr));
      end
      px_ready = $urandom_range(0, 2) != 0;
      if (px_valid && px_ready && n < 8) begin
        acc[n] = {px_reset, px_color};
        n++;
      end
      hold = px_valid && !px_ready;
      pc = px_color;
      pr = px_reset;
      if (frame_done) done = 1'b1;
    end
    check("bp_done", 32'(done), 32'h1);
    check("bp_count", n, 4);
    check("bp_px0", 32'(acc[0]), 32'h0FF0000);
    check("bp_px1", 32'(acc[1]), 32'h000FF00);
    check("bp_px2", 32'(acc[2]), 32'h00000FF);
    check("bp_latch", 32'(acc[3]), 32'h1000000);
    check("main_ovr", 32'(overrun), 32'h0);
    px_ready = 1'b0;
    n = 0;
    while (!px_valid && n < 100) begin
      step();
      n++;
    end
    check("rst_wait", 32'(px_valid), 32'h1);
    check("rst_px1", px_color, 32'hFF0000);
    check("ovr_sticky", 32'(f_overrun), 32'h1);
    rst = 1'b1;
    step();
    check("abort_out", {4'(busy), 4'(frame_done), 4'(px_reset), 4'(px_valid), px_color}, 32'h0);
    check("abort_ovr", {4'(overrun), 4'(f_overrun), 4'(f_valid)}, 32'h0);
    rst = 1'b0;
    px_ready = 1'b1;
    n = 0;
    while (!px_valid && n < 100) begin
      step();
      n++;
    end
    check("buf_keep", px_color, 32'hFF0000);
    enable = 1'b0;
    n = px_valid ? 1 : 0;
    fd = 0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (px_valid && px_ready) begin
        n++;
        if (px_reset) lat++;
      end
      if (frame_done) fd++;
    end
    check("en_accepts", n, 4);
    check("en_latch", lat, 1);
    check("en_done", fd, 1);
    hits = 0;
    for (int i = 0; i < 160; i++) begin
      step();
      if (px_valid || busy) hits++;
    end
    check("en_idle", hits, 0);
    enable = 1'b1;
    dim = 3'd4;
    wr(2'd0, 24'hF08010);
    n = 0;
    while (!px_valid && n < 100) begin
      step();
      n++;
    end
    check("dim_valid", 32'(px_valid), 32'h1);
`ifdef PIXEL_FRAME_DIM_EN
    check("dim_color", px_color, 32'h0F0801);
`else
    check("dim_color", px_color, 32'hF08010);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_frame_ctrl.md
# pixel_frame_ctrl

Frame sequencer for the serial LED chain. It holds a NUM_PX-entry 24-bit colour buffer that host logic writes, and it feeds `pixel_driver` through the same colour/valid/reset/ready handshake that `top` drives today. On every frame tick it streams the pixels in address order, then issues the latch (reset) command. It replaces the ad-hoc counter and rotate logic in `top`.

## Interface
- `NUM_PX`, default 3: pixels per frame; legal range 1..256.
- `FRAME_DIV`, default 266_667: clock cycles between frame ticks (about 60 Hz at 16 MHz); minimum 2.
- `clk` in 1: system clock, 16 MHz; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `enable` in 1: frame ticks start frames only while high.
- `wr_en` in 1: buffer write strobe.
- `wr_addr` in $clog2(NUM_PX) (min 1): pixel index.
- `wr_data` in 24: colour, GRB order as sent on wire, MSB first.
- `dim` in 3: brightness right-shift (only with PIXEL_FRAME_DIM_EN).
- `px_color` out 24: to `pixel_driver.color`.
- `px_valid` out 1: to `pixel_driver.valid`.
- `px_reset` out 1: to `pixel_driver.reset` (latch command).
- `px_ready` in 1: from `pixel_driver.ready`.
- `busy` out 1: frame in progress.
- `frame_done` out 1: one-cycle pulse after latch is accepted.
- `overrun` out 1: sticky; a tick arrived while busy.

## Operation
- Transfer rule: a command is accepted on any cycle where `px_valid && px_ready`.
- Once raised, `px_valid` stays high, and `px_color`/`px_reset` stay stable, until accepted.
- `px_reset` is high only together with `px_valid` in state LATCH.
- Tick counter: 32-bit, counts 0..FRAME_DIV-1 and wraps; `tick` fires when count == FRAME_DIV-1.
- FSM states:
  - IDLE: on `tick && enable`, set idx=0 → LOAD.
  - LOAD: buffer read of idx issued → SEND.
  - SEND: `px_valid=1`, `px_color` = read data. On accept: if idx==NUM_PX-1 → LATCH, else idx+1 → LOAD.
  - LATCH: `px_valid=1`, `px_reset=1`, `px_color=0`. On accept → IDLE and pulse `frame_done`.
- `busy` = state != IDLE.
- Tick while busy: set `overrun`; the tick is dropped, not queued.
- `enable` low mid-frame: the current frame completes, including latch; no further frames start.
- Buffer writes are allowed at any time and are not frame-synchronised.
- Simultaneous write and read of the same address: the read returns the old data (read-first).
- idx width is $clog2(NUM_PX), with a minimum of 1. idx never exceeds NUM_PX-1; there is no wrap inside a frame.
- `rst` mid-frame: abort immediately to IDLE. Buffer contents are retained (not cleared by reset).

## Timing
- Reset values:
  - `px_valid`, `px_reset`, `busy`, `frame_done`, `overrun` = 0; `px_color` = 0.
  - FSM = IDLE; idx = 0; tick counter = 0.
- First tick fires FRAME_DIV-1 cycles after the first cycle with `rst` low.
- Tick at cycle T (IDLE, enable) → LOAD at T+1, `px_valid` high at T+2.
- Accept at cycle k → next `px_valid` at k+2 (one bubble cycle for the buffer read).
- Last pixel accepted at k → latch `px_valid`/`px_reset` at k+1. Latch accepted at m → `frame_done` high at m+1 only; `busy` low at m+1.
- Best-case frame length with `px_ready` always high: 2·NUM_PX + 2 cycles from tick.

## Configuration
- `PIXEL_FRAME_DIM_EN` defined: each 8-bit channel of `px_color` in SEND is logically right-shifted by `dim` (0..7). The shift is combinational on the registered read data and adds no latency.
- Not defined: `dim` is ignored and the colour passes unchanged.

## Structure
- `pixel_pkg`: `color_t` (24-bit), FSM state enum (IDLE, LOAD, SEND, LATCH), `LATCH_COLOR` = 24'h0.
- Sub-module `pixel_frame_ram`: NUM_PX×24 simple dual-port memory, one write port and one registered read port, read-first, no reset.

## Test plan
- Write FF0000/00FF00/0000FF to addresses 0..2, NUM_PX=3, FRAME_DIV=50, `px_ready` held high → accepts in order FF0000, 00FF00, 0000FF, then latch; `frame_done` pulses once; first `px_valid` 2 cycles after tick.
- Random `px_ready` backpressure → `px_color` and `px_valid` stable while unaccepted; no pixel lost or duplicated.
- FRAME_DIV=4 with `px_ready` low → `overrun`=1 and stays 1 until `rst`; frames do not back-to-back queue.
- Assert `rst` during the pixel-1 SEND → next cycle all outputs 0, FSM IDLE; buffer still reads back FF0000.
- Drop `enable` mid-frame → frame finishes with latch, then no `px_valid` for 3 further ticks.
- With PIXEL_FRAME_DIM_EN, dim=4, data 0xF08010 → `px_color` 0x0F0801.
